// File: rtl/meas_pkg.sv
// Shared types and widths for the measurement sequencer.
package meas_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RELEASE,
    S_CONV_REQ,
    S_CONV_WAIT,
    S_ACCUM,
    S_OUTPUT
  } meas_state_e;

  // Timeout counter is wide enough for any TIMEOUT up to 2**16-1.
  localparam int TMO_W = 16;

  // Accumulator width: a full frame of 2**log2n samples cannot overflow it.
  function automatic int acc_width(input int dbits, input int log2n);
    return dbits + log2n;
  endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// Delay-timer and ADC handshake signals of the measurement sequencer.
// master = sequencer side, slave = timer/ADC side.
interface meas_sequencer_if #(
  parameter int MBITS = 7,
  parameter int DBITS = 12
);
  logic             dly_en;
  logic [MBITS-1:0] dly_ms;
  logic             dly_finish;
  logic             adc_start;
  logic             adc_done;
  logic [DBITS-1:0] adc_data;

  modport master (output dly_en, dly_ms, adc_start,
                  input  dly_finish, adc_done, adc_data);
  modport slave  (input  dly_en, dly_ms, adc_start,
                  output dly_finish, adc_done, adc_data);
endinterface

// File: rtl/sample_accumulator.sv
// Frame accumulator: sums samples, counts them and flags the last one of a frame.
// With MEAS_MINMAX_EN defined it also tracks the frame's minimum and maximum sample.
module sample_accumulator
  import meas_pkg::*;
#(
  parameter int DBITS = 12,
  parameter int LOG2N = 3,
  localparam int ACC_W = acc_width(DBITS, LOG2N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [DBITS-1:0] sample_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             last_o
`ifdef MEAS_MINMAX_EN
  ,
  output logic [DBITS-1:0] min_o,
  output logic [DBITS-1:0] max_o
`endif
);

  logic [ACC_W-1:0] acc_q;
  logic [LOG2N-1:0] count_q;

  // Sum and sample count; cleared at every frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (add_i) begin
      acc_q   <= acc_q + ACC_W'(sample_i);
      count_q <= count_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (count_q == {LOG2N{1'b1}});

`ifdef MEAS_MINMAX_EN
  logic [DBITS-1:0] min_q;
  logic [DBITS-1:0] max_q;

  // Running extremes; min starts at full scale so the first sample always replaces it.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      min_q <= '1;
      max_q <= '0;
    end else if (add_i) begin
      if (sample_i < min_q) min_q <= sample_i;
      if (sample_i > max_q) max_q <= sample_i;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: settle delay -> ADC conversion -> accumulate, averaging
// 2**LOG2N samples per frame. Optional feature macro: MEAS_MINMAX_EN (min/max outputs).
//
// state       | meaning
// S_IDLE      | waiting for run, frame state discarded
// S_SETTLE    | delay timer enabled, waiting for finish
// S_RELEASE   | timer enable dropped one cycle so the timer re-arms
// S_CONV_REQ  | one-cycle ADC start pulse
// S_CONV_WAIT | waiting for adc_done, bounded by TIMEOUT
// S_ACCUM     | add captured sample, decide next sample / output / stop
// S_OUTPUT    | publish averaged result
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int MBITS   = 7,
  parameter int DBITS   = 12,
  parameter int LOG2N   = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [MBITS-1:0] settle_ms_i,
  meas_sequencer_if.master bus,
  output logic [DBITS-1:0] result_o,
  output logic             result_valid_o,
  output logic             adc_err_o,
  output logic             busy_o
`ifdef MEAS_MINMAX_EN
  ,
  output logic [DBITS-1:0] min_val_o,
  output logic [DBITS-1:0] max_val_o
`endif
);

  localparam int ACC_W = acc_width(DBITS, LOG2N);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  meas_state_e      state_q, state_d;
  logic [MBITS-1:0] dly_ms_q, dly_ms_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DBITS-1:0] sample_q, sample_d;
  logic [DBITS-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             adc_err_q, adc_err_d;
  logic             run_prev_q;
  logic             acc_clear, acc_add, acc_last;
  logic [ACC_W-1:0] acc;

`ifdef MEAS_MINMAX_EN
  logic [DBITS-1:0] frame_min, frame_max;
  logic [DBITS-1:0] min_val_q, max_val_q;
`endif

  sample_accumulator #(.DBITS(DBITS), .LOG2N(LOG2N)) u_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (acc_clear),
    .add_i    (acc_add),
    .sample_i (sample_q),
    .acc_o    (acc),
    .last_o   (acc_last)
`ifdef MEAS_MINMAX_EN
    ,
    .min_o    (frame_min),
    .max_o    (frame_max)
`endif
  );

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      dly_ms_q       <= '0;
      tmo_q          <= '0;
      sample_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      adc_err_q      <= 1'b0;
      run_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dly_ms_q       <= dly_ms_d;
      tmo_q          <= tmo_d;
      sample_q       <= sample_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      adc_err_q      <= adc_err_d;
      run_prev_q     <= run_i;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d        = state_q;
    dly_ms_d       = dly_ms_q;
    tmo_d          = tmo_q;
    sample_d       = sample_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    adc_err_d      = adc_err_q;
    acc_clear      = 1'b0;
    acc_add        = 1'b0;

    if (run_i && !run_prev_q) adc_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          dly_ms_d  = settle_ms_i;
          acc_clear = 1'b1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.dly_finish) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        tmo_d   = '0;
        state_d = S_CONV_REQ;
      end
      S_CONV_REQ: begin
        // Counting starts here so the error lands TIMEOUT cycles after adc_start.
        tmo_d   = tmo_q + 1'b1;
        state_d = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        if (bus.adc_done) begin
          sample_d = bus.adc_data;
          state_d  = S_ACCUM;
        end else if (tmo_q == TMO_LAST) begin
          adc_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ACCUM: begin
        acc_add = 1'b1;
        if (acc_last)   state_d = S_OUTPUT;
        else if (run_i) state_d = S_SETTLE;
        else            state_d = S_IDLE;
      end
      S_OUTPUT: begin
        result_d       = DBITS'(acc >> LOG2N);
        result_valid_d = 1'b1;
        if (run_i) begin
          dly_ms_d  = settle_ms_i;
          acc_clear = 1'b1;
          state_d   = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEAS_MINMAX_EN
  // Frame extremes published together with the averaged result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_val_q <= '0;
      max_val_q <= '0;
    end else if (state_q == S_OUTPUT) begin
      min_val_q <= frame_min;
      max_val_q <= frame_max;
    end
  end

  assign min_val_o = min_val_q;
  assign max_val_o = max_val_q;
`endif

  // Enable is gated by finish so the timer never sees en high while it reports finish.
  assign bus.dly_en    = (state_q == S_SETTLE) && !bus.dly_finish;
  assign bus.dly_ms    = dly_ms_q;
  assign bus.adc_start = (state_q == S_CONV_REQ);

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign adc_err_o      = adc_err_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer with a behavioural delay timer and ADC model.
module tb_meas_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [6:0]  settle_ms;
  logic [11:0] result;
  logic        result_valid;
  logic        adc_err;
  logic        busy;
`ifdef MEAS_MINMAX_EN
  logic [11:0] min_val, max_val;
`endif

  meas_sequencer_if #(.MBITS(7), .DBITS(12)) bus ();

  meas_sequencer #(.MBITS(7), .DBITS(12), .LOG2N(3), .TIMEOUT(20)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .run_i          (run),
    .settle_ms_i    (settle_ms),
    .bus            (bus),
    .result_o       (result),
    .result_valid_o (result_valid),
    .adc_err_o      (adc_err),
    .busy_o         (busy)
`ifdef MEAS_MINMAX_EN
    ,
    .min_val_o      (min_val),
    .max_val_o      (max_val)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_dones = 0;
  int n_pulses = 0;
  int hs_viol = 0;
  int last_start_cyc = 0;
  logic [11:0] exp_q[$];

  // ADC model controls
  int adc_base = 0;
  int adc_step = 0;
  int base_idx = 0;
  logic adc_mute = 1'b0;

  // Delay timer model: one "ms" per clock, finish after dly_ms+2 enabled cycles.
  int tcnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.dly_en) begin
      tcnt           <= 0;
      bus.dly_finish <= 1'b0;
    end else if (tcnt == int'(bus.dly_ms) + 1) begin
      bus.dly_finish <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  // ADC model: answers two cycles after the start pulse unless muted.
  int lat = 0;
  always @(posedge clk) begin
    bus.adc_done <= 1'b0;
    if (bus.adc_start) begin
      n_starts <= n_starts + 1;
      if (!adc_mute) lat <= 2;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        bus.adc_done <= 1'b1;
        bus.adc_data <= 12'(adc_base + (n_dones - base_idx) * adc_step);
        n_dones      <= n_dones + 1;
      end
    end
  end

  // Scoreboard monitor: compares every result_valid pulse against the queue.
  always @(negedge clk) begin
    if (bus.adc_start) last_start_cyc = cyc;
    if (bus.dly_en && bus.dly_finish) hs_viol++;
    if (result_valid) begin
      n_pulses++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result got=%0d expected no pulse", result);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          n_fail++;
          $display("FAIL result got=%0d exp=%0d", result, e);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic set_adc(input int base, input int step);
    adc_base = base;
    adc_step = step;
    base_idx = n_dones;
  endtask

  task automatic wait_starts(input int target, input int max_cyc, input string name);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (n_starts >= target) break;
    end
    if (i == max_cyc) timeout_fail(name);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == max_cyc) timeout_fail(name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0;
    int i;
    rst = 1'b1; run = 1'b0; settle_ms = 7'd2;
    repeat (3) @(negedge clk);
    check("rst_busy",   int'(busy), 0);
    check("rst_dly_en", int'(bus.dly_en), 0);
    check("rst_result", int'(result), 0);
    check("rst_valid",  int'(result_valid), 0);
    check("rst_err",    int'(adc_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: ramp 100..107 averages to 103
    set_adc(100, 1);
    exp_q.push_back(12'd103);
    p0 = n_pulses;
    run = 1'b1;
    wait_starts(n_starts + 8, 500, "t1_starts");
    run = 1'b0;
    wait_idle(200, "t1_idle");
    check("t1_pulses", n_pulses - p0, 1);
`ifdef MEAS_MINMAX_EN
    check("t1_min", int'(min_val), 100);
    check("t1_max", int'(max_val), 107);
`endif

    // 2: three frames at full scale
    set_adc(4095, 0);
    repeat (3) exp_q.push_back(12'd4095);
    p0 = n_pulses;
    run = 1'b1;
    wait_starts(n_starts + 24, 1500, "t2_starts");
    run = 1'b0;
    wait_idle(200, "t2_idle");
    check("t2_pulses", n_pulses - p0, 3);
    check("t2_result", int'(result), 4095);

    // 3: ADC silent, error TIMEOUT cycles after start
    adc_mute = 1'b1;
    p0 = n_pulses;
    run = 1'b1;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_err) break;
    end
    if (i == 300) timeout_fail("t3_err");
    else begin
      check("t3_err_delay", cyc - last_start_cyc, 20);
      check("t3_busy", int'(busy), 0);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_err_sticky", int'(adc_err), 1);
    check("t3_pulses", n_pulses - p0, 0);
    check("t3_result", int'(result), 4095);
    adc_mute = 1'b0;

    // 4: run dropped during third sample, partial frame discarded
    set_adc(10, 1);
    p0 = n_pulses;
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_err_clear", int'(adc_err), 0);
    wait_starts(n_starts + 3, 300, "t4_starts");
    run = 1'b0;
    wait_idle(200, "t4_idle");
    check("t4_pulses", n_pulses - p0, 0);
    check("t4_result", int'(result), 4095);

    // 5: reset while settling
    settle_ms = 7'd5;
    run = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.dly_en) break;
    end
    if (i == 50) timeout_fail("t5_settle");
    rst = 1'b1;
    @(negedge clk);
    check("t5_dly_en", int'(bus.dly_en), 0);
    check("t5_busy",   int'(busy), 0);
    check("t5_result", int'(result), 0);
    rst = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);

    // 6: zero settle time, handshake never overlaps
    settle_ms = 7'd0;
    set_adc(50, 0);
    exp_q.push_back(12'd50);
    p0 = n_pulses;
    run = 1'b1;
    wait_starts(n_starts + 8, 400, "t6_starts");
    run = 1'b0;
    wait_idle(200, "t6_idle");
    check("t6_pulses", n_pulses - p0, 1);
    check("t6_result", int'(result), 50);
    check("t6_handshake", hs_viol, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
